multicycle_ctrl: RTL and testbench

- Multi-cycle control unit. Replaces the single-cycle decoder so one instruction runs over IF/ID/EXE/MEM/WB states on a shared datapath with an IR, ALU output register and memory data register.
- Sequences PC, IR, register-file and data-memory write enables per state. Decodes the same 6-bit opcode set and ALUOp encoding as the single-cycle unit.

---
 rtl/multicycle_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- multi-cycle control unit for the shared-datapath CPU.
// Runs each instruction over IF/ID/EXE/MEM/WB states and sequences the
// PC, IR, register-file and data-memory write enables for each state.
//
// Ports:
//   CLK        rising-edge clock
//   Reset      asynchronous active-low reset
//   op         opcode from the IR output
//   zero/sign  ALU flags, combinational in the current cycle
//   state      current state code (debug)
//   PCWre      PC load enable (once per instruction, in its final state)
//   IRWre      IR load enable (IF only)
//   InsMemRW   instruction memory read/write (always read = 0)
//   RegWre     register-file write enable
//   RegDst     1 = rd, 0 = rt
//   ExtSel     1 = sign-extend, 0 = zero-extend
//   ALUSrcA    1 = shamt, 0 = rs
//   ALUSrcB    1 = extended immediate, 0 = rt
//   ALUOp      ADD 000, SUB 001, SLL 010, OR 011, AND 100, SLTU 101, SLT 110, XOR 111
//   PCSrc      00 PC+4, 10 branch target, 01 jump target, 11 register target
//   mRD/mWR    data memory read / write
//   DBDataSrc  1 = memory data register, 0 = ALU output register
//   halted     high while halted
//   WrRegDSrc  0 selects $31 as write register (MC_JUMP_LINK_EN only)
//
// Build option: define MC_JUMP_LINK_EN to add JAL (111010) and JR (111001).
// Without it both opcodes are treated as undefined (2-cycle no-ops).
module multicycle_ctrl #(
  parameter int OPW = 6,
  parameter int STW = 3
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] op,
  input  logic           zero,
  input  logic           sign,
  output logic [STW-1:0] state,
  output logic           PCWre,
  output logic           IRWre,
  output logic           InsMemRW,
  output logic           RegWre,
  output logic           RegDst,
  output logic           ExtSel,
  output logic           ALUSrcA,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           mRD,
  output logic           mWR,
  output logic           DBDataSrc,
  output logic           halted
`ifdef MC_JUMP_LINK_EN
  ,
  output logic           WrRegDSrc
`endif
);

  localparam logic [OPW-1:0] OP_ADD   = 6'b000000;
  localparam logic [OPW-1:0] OP_SUB   = 6'b000001;
  localparam logic [OPW-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b010000;
  localparam logic [OPW-1:0] OP_AND   = 6'b010001;
  localparam logic [OPW-1:0] OP_ORI   = 6'b010010;
  localparam logic [OPW-1:0] OP_OR    = 6'b010011;
  localparam logic [OPW-1:0] OP_SLL   = 6'b011000;
  localparam logic [OPW-1:0] OP_SLTI  = 6'b011100;
  localparam logic [OPW-1:0] OP_SW    = 6'b100110;
  localparam logic [OPW-1:0] OP_LW    = 6'b100111;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b110000;
  localparam logic [OPW-1:0] OP_BNE   = 6'b110001;
  localparam logic [OPW-1:0] OP_BLTZ  = 6'b110010;
  localparam logic [OPW-1:0] OP_J     = 6'b111000;
  localparam logic [OPW-1:0] OP_HALT  = 6'b111111;
`ifdef MC_JUMP_LINK_EN
  localparam logic [OPW-1:0] OP_JR    = 6'b111001;
  localparam logic [OPW-1:0] OP_JAL   = 6'b111010;
`endif

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;

  typedef enum logic [STW-1:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    C_AL, C_BR, C_LS, C_JMP, C_NOP, C_HALT, C_JAL, C_JR
  } opClass_t;

  state_t         curState;
  logic           haltFlag;
  logic [OPW-1:0] opLatch;
  opClass_t       idClass;
  logic           brTaken;
  logic           pcWreRaw;
  logic           irWreRaw;
  logic           regWreRaw;
  logic           mWrRaw;
`ifdef MC_JUMP_LINK_EN
  logic           jalFlag;
`endif

  // ID decides the next state from the live IR output; later states only
  // ever look at opLatch.
  always_comb begin
    idClass = C_NOP;
    case (op)
      OP_ADD, OP_SUB, OP_ADDIU, OP_ANDI, OP_AND,
      OP_ORI, OP_OR, OP_SLL, OP_SLTI:   idClass = C_AL;
      OP_BEQ, OP_BNE, OP_BLTZ:          idClass = C_BR;
      OP_SW, OP_LW:                     idClass = C_LS;
      OP_J:                             idClass = C_JMP;
      OP_HALT:                          idClass = C_HALT;
`ifdef MC_JUMP_LINK_EN
      OP_JAL:                           idClass = C_JAL;
      OP_JR:                            idClass = C_JR;
`endif
      default:                          idClass = C_NOP;
    endcase
  end

  // HALT shares code 000 with IF; haltFlag pins the FSM there until reset.
  // WB_JAL likewise shares code 111 with WB_AL, told apart by jalFlag.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      curState <= S_IF;
      haltFlag <= 1'b0;
      opLatch  <= '0;
`ifdef MC_JUMP_LINK_EN
      jalFlag  <= 1'b0;
`endif
    end else begin
      case (curState)
        S_IF: if (!haltFlag) curState <= S_ID;
        S_ID: begin
          opLatch <= op;
          case (idClass)
            C_AL:   curState <= S_EXE_AL;
            C_BR:   curState <= S_EXE_BR;
            C_LS:   curState <= S_EXE_LS;
            C_HALT: begin
              curState <= S_IF;
              haltFlag <= 1'b1;
            end
`ifdef MC_JUMP_LINK_EN
            C_JAL: begin
              curState <= S_WB_AL;
              jalFlag  <= 1'b1;
            end
`endif
            default: curState <= S_IF;
          endcase
        end
        S_EXE_AL: curState <= S_WB_AL;
        S_WB_AL: begin
          curState <= S_IF;
`ifdef MC_JUMP_LINK_EN
          jalFlag  <= 1'b0;
`endif
        end
        S_EXE_BR: curState <= S_IF;
        S_EXE_LS: curState <= S_MEM;
        S_MEM:    curState <= (opLatch == OP_LW) ? S_WB_LD : S_IF;
        S_WB_LD:  curState <= S_IF;
        default:  curState <= S_IF;
      endcase
    end
  end

  always_comb begin
    brTaken = 1'b0;
    case (opLatch)
      OP_BEQ:  brTaken = zero;
      OP_BNE:  brTaken = !zero;
      OP_BLTZ: brTaken = sign;
      default: brTaken = 1'b0;
    endcase
  end

  // Sequencing outputs. PCSrc and the ID-state enables must follow the live
  // opcode/flags within the cycle, so these are decoded from the state
  // register rather than registered themselves.
  always_comb begin
    pcWreRaw  = 1'b0;
    irWreRaw  = 1'b0;
    regWreRaw = 1'b0;
    mWrRaw    = 1'b0;
    mRD       = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = 2'b00;
`ifdef MC_JUMP_LINK_EN
    WrRegDSrc = 1'b1;
`endif
    case (curState)
      S_IF: irWreRaw = !haltFlag;
      S_ID: begin
        case (idClass)
          C_JMP: begin
            pcWreRaw = 1'b1;
            PCSrc    = 2'b01;
          end
          C_NOP: pcWreRaw = 1'b1;
`ifdef MC_JUMP_LINK_EN
          C_JR: begin
            pcWreRaw = 1'b1;
            PCSrc    = 2'b11;
          end
`endif
          default: ;
        endcase
      end
      S_EXE_BR: begin
        pcWreRaw = 1'b1;
        if (brTaken) PCSrc = 2'b10;
      end
      S_WB_AL: begin
        pcWreRaw  = 1'b1;
        regWreRaw = 1'b1;
`ifdef MC_JUMP_LINK_EN
        if (jalFlag) begin
          PCSrc     = 2'b01;
          WrRegDSrc = 1'b0;
        end
`endif
      end
      S_MEM: begin
        mRD      = (opLatch == OP_LW);
        mWrRaw   = (opLatch == OP_SW);
        pcWreRaw = (opLatch == OP_SW);
      end
      S_WB_LD: begin
        pcWreRaw  = 1'b1;
        regWreRaw = 1'b1;
        DBDataSrc = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath selects come only from the latched opcode, so they hold steady
  // while the IR changes in IF/ID.
  always_comb begin
    RegDst  = 1'b1;
    ExtSel  = 1'b1;
    ALUSrcA = 1'b0;
    ALUSrcB = 1'b0;
    ALUOp   = ALU_ADD;
    case (opLatch)
      OP_ADDIU: begin
        RegDst  = 1'b0;
        ALUSrcB = 1'b1;
      end
      OP_ANDI: begin
        RegDst  = 1'b0;
        ExtSel  = 1'b0;
        ALUSrcB = 1'b1;
        ALUOp   = ALU_AND;
      end
      OP_ORI: begin
        RegDst  = 1'b0;
        ExtSel  = 1'b0;
        ALUSrcB = 1'b1;
        ALUOp   = ALU_OR;
      end
      OP_SLTI: begin
        RegDst  = 1'b0;
        ALUSrcB = 1'b1;
        ALUOp   = ALU_SLT;
      end
      OP_LW: begin
        RegDst  = 1'b0;
        ALUSrcB = 1'b1;
      end
      OP_SW:                           ALUSrcB = 1'b1;
      OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ALUOp = ALU_SUB;
      OP_SLL: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_SLL;
      end
      OP_OR:   ALUOp = ALU_OR;
      OP_AND:  ALUOp = ALU_AND;
      default: ;
    endcase
  end

  // Write enables are gated by Reset so they drop the instant reset
  // asserts, even mid-cycle.
  assign PCWre    = pcWreRaw & Reset;
  assign IRWre    = irWreRaw & Reset;
  assign RegWre   = regWreRaw & Reset;
  assign mWR      = mWrRaw & Reset;
  assign InsMemRW = 1'b0;
  assign state    = curState;
  assign halted   = haltFlag;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a directed per-instruction table,
// randomized instruction streams against an instruction-level reference
// model, and hand-written reset/halt sequences.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b010000;
  localparam logic [5:0] OP_AND   = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_OR    = 6'b010011;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_UNDEF = 6'b101010;

  localparam int K_AL = 0, K_BR = 1, K_SW = 2, K_LW = 3, K_J = 4,
                 K_NOP = 5, K_HALT = 6, K_JAL = 7, K_JR = 8;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] op;
  logic       zero, sign;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, RegWre, RegDst, ExtSel, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;
  logic       mRD, mWR, DBDataSrc, halted;
`ifdef MC_JUMP_LINK_EN
  logic       WrRegDSrc;
`endif

  int total = 0;
  int bad   = 0;

  multicycle_ctrl #(.OPW(6), .STW(3)) dut (
    .CLK(CLK), .Reset(Reset), .op(op), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .RegWre(RegWre), .RegDst(RegDst), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .mRD(mRD), .mWR(mWR),
    .DBDataSrc(DBDataSrc), .halted(halted)
`ifdef MC_JUMP_LINK_EN
    , .WrRegDSrc(WrRegDSrc)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    int st; int pcSrc; int aluOp;
    bit pcWre, irWre, regWre, mRd, mWr, dbSrc, wrRegDSrc;
    bit chkDec, regDst, extSel, srcA, srcB;
  } exp_t;

  typedef struct {
    logic [5:0] op; bit z; bit s;
    int len; int pcs; int alu; int nReg; int nWr;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int clsOf(input logic [5:0] o);
    case (o)
      OP_ADD, OP_SUB, OP_ADDIU, OP_ANDI, OP_AND,
      OP_ORI, OP_OR, OP_SLL, OP_SLTI: return K_AL;
      OP_BEQ, OP_BNE, OP_BLTZ:        return K_BR;
      OP_SW:   return K_SW;
      OP_LW:   return K_LW;
      OP_J:    return K_J;
      OP_HALT: return K_HALT;
`ifdef MC_JUMP_LINK_EN
      OP_JAL:  return K_JAL;
      OP_JR:   return K_JR;
`endif
      default: return K_NOP;
    endcase
  endfunction

  function automatic int lenOf(input int c);
    case (c)
      K_AL, K_SW: return 4;
      K_BR, K_JAL: return 3;
      K_LW: return 5;
      default: return 2;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = IF) of one instruction.
  function automatic exp_t model(input logic [5:0] o, input int k, input bit z, input bit s);
    exp_t e;
    int c, n;
    int seq[5];
    bit taken, fin;
    c = clsOf(o);
    n = lenOf(c);
    case (c)
      K_AL:       seq = '{0, 1, 6, 7, 0};
      K_BR:       seq = '{0, 1, 5, 0, 0};
      K_SW, K_LW: seq = '{0, 1, 2, 3, 4};
      K_JAL:      seq = '{0, 1, 7, 0, 0};
      default:    seq = '{0, 1, 0, 0, 0};
    endcase
    fin   = (k == n - 1);
    taken = (o == OP_BEQ && z) || (o == OP_BNE && !z) || (o == OP_BLTZ && s);
    e.st        = seq[k];
    e.pcWre     = fin && (c != K_HALT);
    e.irWre     = (k == 0);
    e.regWre    = fin && (c == K_AL || c == K_LW || c == K_JAL);
    e.mRd       = (c == K_LW) && (k == 3);
    e.mWr       = (c == K_SW) && (k == 3);
    e.dbSrc     = (c == K_LW) && (k == 4);
    e.wrRegDSrc = !((c == K_JAL) && (k == 2));
    e.pcSrc     = 0;
    if ((c == K_J && k == 1) || (c == K_JAL && k == 2)) e.pcSrc = 1;
    if (c == K_JR && k == 1) e.pcSrc = 3;
    if (c == K_BR && k == 2 && taken) e.pcSrc = 2;
    e.chkDec = (k >= 2);
    e.regDst = !(o inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_LW});
    e.extSel = !(o inside {OP_ANDI, OP_ORI});
    e.srcA   = (o == OP_SLL);
    e.srcB   = (o inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI, OP_SW, OP_LW});
    if (o inside {OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ}) e.aluOp = 1;
    else if (o == OP_SLL) e.aluOp = 2;
    else if (o inside {OP_OR, OP_ORI}) e.aluOp = 3;
    else if (o inside {OP_AND, OP_ANDI}) e.aluOp = 4;
    else if (o == OP_SLTI) e.aluOp = 6;
    else e.aluOp = 0;
    return e;
  endfunction

  task automatic cmpExp(input string t, input exp_t e);
    chk($sformatf("%s.state", t), int'(state), e.st);
    chk($sformatf("%s.PCWre", t), int'(PCWre), int'(e.pcWre));
    chk($sformatf("%s.IRWre", t), int'(IRWre), int'(e.irWre));
    chk($sformatf("%s.RegWre", t), int'(RegWre), int'(e.regWre));
    chk($sformatf("%s.mRD", t), int'(mRD), int'(e.mRd));
    chk($sformatf("%s.mWR", t), int'(mWR), int'(e.mWr));
    chk($sformatf("%s.DBDataSrc", t), int'(DBDataSrc), int'(e.dbSrc));
    chk($sformatf("%s.PCSrc", t), int'(PCSrc), e.pcSrc);
    chk($sformatf("%s.halted", t), int'(halted), 0);
    chk($sformatf("%s.InsMemRW", t), int'(InsMemRW), 0);
`ifdef MC_JUMP_LINK_EN
    chk($sformatf("%s.WrRegDSrc", t), int'(WrRegDSrc), int'(e.wrRegDSrc));
`endif
    if (e.chkDec) begin
      chk($sformatf("%s.RegDst", t), int'(RegDst), int'(e.regDst));
      chk($sformatf("%s.ExtSel", t), int'(ExtSel), int'(e.extSel));
      chk($sformatf("%s.ALUSrcA", t), int'(ALUSrcA), int'(e.srcA));
      chk($sformatf("%s.ALUSrcB", t), int'(ALUSrcB), int'(e.srcB));
      chk($sformatf("%s.ALUOp", t), int'(ALUOp), e.aluOp);
    end
  endtask

  // Runs nCyc cycles of instruction o; entered and left just after a negedge.
  // The IR only holds o in ID; other cycles carry garbage to prove the latch.
  task automatic runInstr(input logic [5:0] o, input int nCyc, input string t);
    for (int k = 0; k < nCyc; k++) begin
      op   = (k == 1) ? o : 6'($urandom_range(0, 63));
      zero = 1'($urandom_range(0, 1));
      sign = 1'($urandom_range(0, 1));
      #1;
      cmpExp($sformatf("%s.c%0d", t, k), model(o, k, zero, sign));
      @(negedge CLK);
    end
  endtask

  task automatic runVec(input logic [5:0] o, input bit z, input bit s,
                        output int len, output int pcs, output int alu,
                        output int nPc, output int nReg, output int nWr);
    int k;
    k = 0; pcs = -1; alu = -1; nPc = 0; nReg = 0; nWr = 0;
    do begin
      op   = (k == 1) ? o : 6'($urandom_range(0, 63));
      zero = (k == 2) ? z : 1'($urandom_range(0, 1));
      sign = (k == 2) ? s : 1'($urandom_range(0, 1));
      #1;
      if (PCWre) begin
        nPc++;
        pcs = int'(PCSrc);
      end
      if (k == 2) alu = int'(ALUOp);
      if (RegWre) nReg++;
      if (mWR) nWr++;
      @(negedge CLK);
      k++;
    end while (state != 3'b000 && k < 8);
    len = k;
  endtask

  vec_t tbl[21];
  logic [5:0] known[19];

  initial begin
    int len, pcs, alu, nPc, nReg, nWr;
    logic [5:0] o;

    tbl[0]  = '{OP_ADD,   0, 0, 4, 0, 0, 1, 0};
    tbl[1]  = '{OP_SUB,   0, 0, 4, 0, 1, 1, 0};
    tbl[2]  = '{OP_ADDIU, 0, 0, 4, 0, 0, 1, 0};
    tbl[3]  = '{OP_ANDI,  0, 0, 4, 0, 4, 1, 0};
    tbl[4]  = '{OP_AND,   0, 0, 4, 0, 4, 1, 0};
    tbl[5]  = '{OP_ORI,   0, 0, 4, 0, 3, 1, 0};
    tbl[6]  = '{OP_OR,    0, 0, 4, 0, 3, 1, 0};
    tbl[7]  = '{OP_SLL,   0, 0, 4, 0, 2, 1, 0};
    tbl[8]  = '{OP_SLTI,  0, 0, 4, 0, 6, 1, 0};
    tbl[9]  = '{OP_BEQ,   1, 0, 3, 2, 1, 0, 0};
    tbl[10] = '{OP_BEQ,   0, 1, 3, 0, 1, 0, 0};
    tbl[11] = '{OP_BNE,   0, 0, 3, 2, 1, 0, 0};
    tbl[12] = '{OP_BNE,   1, 1, 3, 0, 1, 0, 0};
    tbl[13] = '{OP_BLTZ,  1, 1, 3, 2, 1, 0, 0};
    tbl[14] = '{OP_BLTZ,  0, 0, 3, 0, 1, 0, 0};
    tbl[15] = '{OP_SW,    0, 0, 4, 0, 0, 0, 1};
    tbl[16] = '{OP_LW,    0, 0, 5, 0, 0, 1, 0};
    tbl[17] = '{OP_J,     0, 0, 2, 1, -1, 0, 0};
    tbl[18] = '{OP_UNDEF, 0, 0, 2, 0, -1, 0, 0};
`ifdef MC_JUMP_LINK_EN
    tbl[19] = '{OP_JAL,   0, 0, 3, 1, 0, 1, 0};
    tbl[20] = '{OP_JR,    0, 0, 2, 3, -1, 0, 0};
`else
    tbl[19] = '{OP_JAL,   0, 0, 2, 0, -1, 0, 0};
    tbl[20] = '{OP_JR,    0, 0, 2, 0, -1, 0, 0};
`endif
    known = '{OP_ADD, OP_SUB, OP_ADDIU, OP_ANDI, OP_AND, OP_ORI, OP_OR,
              OP_SLL, OP_SLTI, OP_BEQ, OP_BNE, OP_BLTZ, OP_SW, OP_LW,
              OP_J, OP_JR, OP_JAL, OP_UNDEF, OP_ADD};

    // Reset held for three cycles: write enables low, IF values elsewhere.
    Reset = 1'b0; op = '0; zero = 1'b0; sign = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      op = 6'($urandom_range(0, 63));
      #1;
      chk("rst.state", int'(state), 0);
      chk("rst.halted", int'(halted), 0);
      chk("rst.PCWre", int'(PCWre), 0);
      chk("rst.IRWre", int'(IRWre), 0);
      chk("rst.RegWre", int'(RegWre), 0);
      chk("rst.mWR", int'(mWR), 0);
      chk("rst.mRD", int'(mRD), 0);
      chk("rst.PCSrc", int'(PCSrc), 0);
      chk("rst.DBDataSrc", int'(DBDataSrc), 0);
      chk("rst.RegDst", int'(RegDst), 1);
      chk("rst.ExtSel", int'(ExtSel), 1);
      chk("rst.ALUSrcB", int'(ALUSrcB), 0);
      chk("rst.ALUOp", int'(ALUOp), 0);
    end
    @(negedge CLK);
    Reset = 1'b1;
    runInstr(OP_ADD, 4, "add0");

    // Directed table: length, final PCSrc, one PCWre, write-enable counts.
    for (int i = 0; i < 21; i++) begin
      runVec(tbl[i].op, tbl[i].z, tbl[i].s, len, pcs, alu, nPc, nReg, nWr);
      chk($sformatf("tbl%0d.len", i), len, tbl[i].len);
      chk($sformatf("tbl%0d.PCSrc", i), pcs, tbl[i].pcs);
      chk($sformatf("tbl%0d.nPCWre", i), nPc, 1);
      chk($sformatf("tbl%0d.nRegWre", i), nReg, tbl[i].nReg);
      chk($sformatf("tbl%0d.nmWR", i), nWr, tbl[i].nWr);
      if (tbl[i].alu >= 0) chk($sformatf("tbl%0d.ALUOp", i), alu, tbl[i].alu);
    end

    // Random instruction stream against the reference model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) o = 6'($urandom_range(0, 63));
      else o = known[$urandom_range(0, 18)];
      if (o == OP_HALT) o = OP_UNDEF;
      runInstr(o, lenOf(clsOf(o)), $sformatf("rnd%0d", i));
    end

    // SW interrupted by reset during MEM: mWR must fall with no clock edge.
    runInstr(OP_SW, 3, "swr");
    op = 6'($urandom_range(0, 63));
    #1;
    chk("swr.memWr", int'(mWR), 1);
    #1;
    Reset = 1'b0;
    #1;
    chk("swr.mWRdrop", int'(mWR), 0);
    chk("swr.state", int'(state), 0);
    chk("swr.PCWre", int'(PCWre), 0);
    chk("swr.IRWre", int'(IRWre), 0);
    @(negedge CLK);
    Reset = 1'b1;
    runInstr(OP_ADD, 4, "afterSw");

    // HALT: stays put for 20 cycles, then a mid-cycle reset clears it.
    runInstr(OP_HALT, 2, "halt");
    for (int i = 0; i < 20; i++) begin
      op   = 6'($urandom_range(0, 63));
      zero = 1'($urandom_range(0, 1));
      sign = 1'($urandom_range(0, 1));
      #1;
      chk($sformatf("halt%0d.halted", i), int'(halted), 1);
      chk($sformatf("halt%0d.state", i), int'(state), 0);
      chk($sformatf("halt%0d.PCWre", i), int'(PCWre), 0);
      chk($sformatf("halt%0d.IRWre", i), int'(IRWre), 0);
      chk($sformatf("halt%0d.RegWre", i), int'(RegWre), 0);
      chk($sformatf("halt%0d.mWR", i), int'(mWR), 0);
      @(negedge CLK);
    end
    #2;
    Reset = 1'b0;
    #1;
    chk("haltRst.halted", int'(halted), 0);
    chk("haltRst.state", int'(state), 0);
    @(negedge CLK);
    Reset = 1'b1;
    runInstr(OP_LW, 5, "afterHalt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
